// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a length-prefixed byte stream from the UART into
// 32-bit words and writes them to the instruction RAM while holding the CPU in reset.
module imem_loader #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

  localparam int unsigned IW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_DONE,
    S_ERROR
  } state_e;

  state_e        state_q, state_d;
  logic [15:0]   len_q, len_d;
  logic [15:0]   word_idx_q, word_idx_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic [23:0]   acc_q, acc_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          last_q, last_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          timed_out;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      acc_q      <= '0;
      idle_q     <= '0;
      last_q     <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      acc_q      <= acc_d;
      idle_q     <= idle_d;
      last_q     <= last_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  // This idle cycle would be the TIMEOUT-th consecutive one without a byte.
  assign timed_out = !rx_valid && (idle_q == IW'(TIMEOUT - 1));

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    acc_d      = acc_q;
    idle_d     = idle_q;
    last_d     = last_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d    = S_LEN_HI;
          len_d      = '0;
          word_idx_d = '0;
          byte_idx_d = '0;
          acc_d      = '0;
          idle_d     = '0;
          last_d     = 1'b0;
        end
      end

      S_LEN_HI: begin
        if (rx_valid) begin
          len_d[15:8] = rx_data;
          idle_d      = '0;
          state_d     = S_LEN_LO;
        end else if (timed_out) begin
          state_d = S_ERROR;
        end else begin
          idle_d = idle_q + IW'(1);
        end
      end

      S_LEN_LO: begin
        if (rx_valid) begin
          len_d  = {len_q[15:8], rx_data};
          idle_d = '0;
          if (len_d == 16'd0) begin
            state_d = S_DONE;
          end else if ({16'd0, len_d} > DEPTH) begin
            state_d = S_ERROR;
          end else begin
            state_d = S_DATA;
          end
        end else if (timed_out) begin
          state_d = S_ERROR;
        end else begin
          idle_d = idle_q + IW'(1);
        end
      end

      S_DATA: begin
        // last_q marks the cycle the final write is on the bus; the CPU is released after it.
        if (last_q) begin
          last_d  = 1'b0;
          state_d = S_DONE;
        end else if (rx_valid) begin
          idle_d     = '0;
          acc_d      = {acc_q[15:0], rx_data};
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            we_d       = 1'b1;
            wdata_d    = {acc_q, rx_data};
            addr_d     = {14'd0, word_idx_q, 2'b00};
            word_idx_d = word_idx_q + 16'd1;
            if (word_idx_d == len_q) begin
              last_d = 1'b1;
            end
          end
        end else if (timed_out) begin
          state_d = S_ERROR;
        end else begin
          idle_d = idle_q + IW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_hold   = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) || (state_q == S_DATA);
  assign done       = (state_q == S_DONE);
  assign err        = (state_q == S_ERROR);

endmodule

// File: tb/tb_imem_loader.sv
// Randomized + directed bench for imem_loader, checked every cycle against a byte-count
// based model of the load protocol.
module tb_imem_loader;
  localparam int TO    = 64;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        imem_we;
  logic [31:0] imem_addr, imem_wdata;
  logic        cpu_hold, done, err;

  imem_loader #(.DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Model: a load is a count of bytes received; everything follows from that count.
  bit          m_valid = 0;
  bit          m_loading, m_finishing, m_done, m_err, m_we;
  int          m_nbytes, m_idle, m_n;
  logic [31:0] m_word, m_addr, m_wdata;

  always @(posedge clk) begin
    if (!reset) begin
      m_valid = 1; m_loading = 0; m_finishing = 0; m_done = 0; m_err = 0; m_we = 0;
      m_nbytes = 0; m_idle = 0; m_n = 0; m_word = 0; m_addr = 0; m_wdata = 0;
    end else if (m_valid) begin
      m_we = 0;
      if (m_finishing) begin
        m_finishing = 0; m_loading = 0; m_done = 1;
      end else if (!m_loading) begin
        if (start) begin
          m_loading = 1; m_done = 0; m_err = 0; m_nbytes = 0; m_idle = 0;
        end
      end else if (rx_valid) begin
        m_idle = 0;
        m_nbytes++;
        if (m_nbytes == 1) m_n = int'(rx_data) * 256;
        else if (m_nbytes == 2) begin
          m_n += int'(rx_data);
          if (m_n == 0) begin m_loading = 0; m_done = 1; end
          else if (m_n > DEPTH) begin m_loading = 0; m_err = 1; end
        end else begin
          m_word = (m_word << 8) | 32'(rx_data);
          if ((m_nbytes - 2) % 4 == 0) begin
            m_we    = 1;
            m_wdata = m_word;
            m_addr  = 32'(((m_nbytes - 2) / 4 - 1) * 4);
            if ((m_nbytes - 2) / 4 == m_n) m_finishing = 1;
          end
        end
      end else begin
        m_idle++;
        if (m_idle == TO) begin m_loading = 0; m_err = 1; end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("imem_we", 32'(imem_we), 32'(m_we));
      chk("imem_addr", imem_addr, m_addr);
      chk("imem_wdata", imem_wdata, m_wdata);
      chk("cpu_hold", 32'(cpu_hold), 32'(m_loading));
      chk("done", 32'(done), 32'(m_done));
      chk("err", 32'(err), 32'(m_err));
    end
  end

  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  always @(posedge clk) begin
    #1;
    if (imem_we === 1'b1) begin
      log_addr.push_back(imem_addr);
      log_data.push_back(imem_wdata);
    end
  end

  task automatic tick(input logic s, input logic v, input logic [7:0] d);
    @(negedge clk);
    start = s; rx_valid = v; rx_data = d;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic send(input logic [7:0] b);
    tick(1'b0, 1'b1, b);
    repeat ($urandom_range(0, 2)) tick(1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset = 1'b0; start = 1'b0; rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_hold", 32'(cpu_hold), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    reset = 1'b1;
  endtask

  task automatic clear_log;
    log_addr.delete();
    log_data.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] fr[$];

    do_reset();
    idle(2);

    // 1: two-word image
    clear_log();
    tick(1'b1, 1'b0, 8'h00);
    foreach (fr[i]) fr.delete(i);
    fr = '{8'h00, 8'h02, 8'h20, 8'h04, 8'h00, 8'h03, 8'h10, 8'h00, 8'hFF, 8'hFF};
    foreach (fr[i]) send(fr[i]);
    idle(3);
    chk("t1_nwrites", 32'(log_addr.size()), 32'd2);
    if (log_addr.size() == 2) begin
      chk("t1_addr0", log_addr[0], 32'h0);
      chk("t1_data0", log_data[0], 32'h20040003);
      chk("t1_addr1", log_addr[1], 32'h4);
      chk("t1_data1", log_data[1], 32'h1000FFFF);
    end
    chk("t1_model_wdata", m_wdata, 32'h1000FFFF);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_hold", 32'(cpu_hold), 32'd0);

    // 2: empty image
    clear_log();
    tick(1'b1, 1'b0, 8'h00);
    send(8'h00); send(8'h00);
    idle(2);
    chk("t2_nwrites", 32'(log_addr.size()), 32'd0);
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_err", 32'(err), 32'd0);

    // 3: oversize image
    clear_log();
    tick(1'b1, 1'b0, 8'h00);
    send(8'h01); send(8'h01);
    repeat (8) send(8'($urandom));
    idle(2);
    chk("t3_nwrites", 32'(log_addr.size()), 32'd0);
    chk("t3_err", 32'(err), 32'd1);
    chk("t3_model_err", 32'(m_err), 32'd1);

    // 4: timeout in the middle of a word
    clear_log();
    tick(1'b1, 1'b0, 8'h00);
    tick(1'b0, 1'b1, 8'h00); tick(1'b0, 1'b1, 8'h01);
    tick(1'b0, 1'b1, 8'h20); tick(1'b0, 1'b1, 8'h04);
    idle(TO + 5);
    chk("t4_nwrites", 32'(log_addr.size()), 32'd0);
    chk("t4_err", 32'(err), 32'd1);
    chk("t4_hold", 32'(cpu_hold), 32'd0);

    // 5: reset mid-load, then a clean one-word load
    tick(1'b1, 1'b0, 8'h00);
    send(8'h00); send(8'h01); send(8'h08); send(8'h00);
    do_reset();
    clear_log();
    tick(1'b1, 1'b0, 8'h00);
    fr = '{8'h00, 8'h01, 8'h08, 8'h00, 8'h00, 8'h03};
    foreach (fr[i]) send(fr[i]);
    idle(3);
    chk("t5_nwrites", 32'(log_addr.size()), 32'd1);
    if (log_addr.size() == 1) begin
      chk("t5_addr", log_addr[0], 32'h0);
      chk("t5_data", log_data[0], 32'h08000003);
    end
    chk("t5_done", 32'(done), 32'd1);

    // 6: stray bytes while idle, start+byte together, start pulse mid-frame
    clear_log();
    tick(1'b0, 1'b1, 8'h55);
    tick(1'b1, 1'b1, 8'h00);
    send(8'h00); send(8'h01); send(8'hAB);
    tick(1'b1, 1'b0, 8'h00);
    send(8'hCD); send(8'hEF); send(8'h01);
    idle(3);
    chk("t6_nwrites", 32'(log_addr.size()), 32'd1);
    if (log_addr.size() == 1) begin
      chk("t6_addr", log_addr[0], 32'h0);
      chk("t6_data", log_data[0], 32'hABCDEF01);
    end
    chk("t6_done", 32'(done), 32'd1);

    // Random frames with gaps, stray strobes, timeouts, extra starts and resets
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 3) == 0) tick(1'b0, 1'b1, 8'($urandom));
      if ($urandom_range(0, 4) == 0) tick(1'b1, 1'b1, 8'($urandom));
      else tick(1'b1, 1'b0, 8'h00);
      n = ($urandom_range(0, 7) == 0) ? 257 + $urandom_range(0, 300) : $urandom_range(0, 5);
      fr.delete();
      fr.push_back(n[15:8]);
      fr.push_back(n[7:0]);
      if (n <= DEPTH) for (int k = 0; k < 4 * n; k++) fr.push_back(8'($urandom));
      foreach (fr[i]) begin
        if ($urandom_range(0, 80) == 0) idle(TO + 2);
        if ($urandom_range(0, 120) == 0) do_reset();
        if ($urandom_range(0, 25) == 0) tick(1'b1, 1'b0, 8'h00);
        send(fr[i]);
      end
      idle(3);
    end

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
